// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: opcodes, ALU select codes, control-strobe bit map and RUN
// encoding shared by the sequencer control unit and its step ring.
package seq_ctrl_pkg;

    localparam logic [1:0] RUN = 2'b11;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_INC = 4'h3,
        OP_DEC  = 4'h4, OP_JPNZ = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_NOT  = 4'h8, OP_SHL = 4'h9, OP_CLR = 4'hA, OP_MVR = 4'hB,
        OP_JMP  = 4'hC, OP_JPZ = 4'hD, OP_LAD = 4'hE, OP_STO = 4'hF
    } opcode_t;

    localparam int CTRL_W = 21;
    localparam int READ   = 0,  WRITE  = 1,  ARLOAD = 2,  ARINC  = 3,
                   PCINC  = 4,  PCLOAD = 5,  DRLOAD = 6,  TRLOAD = 7,
                   IRLOAD = 8,  R1LOAD = 9,  R0LOAD = 10, XLOAD  = 11,
                   ZLOAD  = 12, PCBUS  = 13, DRHBUS = 14, DRLBUS = 15,
                   TRBUS  = 16, R1BUS  = 17, R0BUS  = 18, MEMBUS = 19,
                   BUSMEM = 20;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Register load / increment strobes (ARLOAD..ZLOAD) suppressed during a memory stall
    localparam ctrl_t LOAD_MASK = 21'h01FFC;

    localparam logic [3:0] ALU_CLR  = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0010,
                           ALU_INC  = 4'b0011, ALU_DEC = 4'b0100, ALU_AND = 4'b0101,
                           ALU_OR   = 4'b0110, ALU_NOT = 4'b0111, ALU_SHL = 4'b1001,
                           ALU_PASS = 4'b1010;

    function automatic logic [3:0] alus_of(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            OP_DEC:  return ALU_DEC;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            OP_SHL:  return ALU_SHL;
            OP_CLR:  return ALU_CLR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/seq_ctrl_unit_ring.sv
// seq_step_ring: one-hot timing-step ring; restart wins over advance, and
// with neither asserted the current step is held.
module seq_step_ring #(
    parameter int NSTEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    output logic [NSTEP-1:0] step
);

    localparam logic [NSTEP-1:0] T0 = {{(NSTEP-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step <= T0;
        end else if (restart) begin
            step <= T0;
        end else if (advance) begin
            step <= {step[NSTEP-2:0], step[NSTEP-1]};
        end
    end

endmodule

// File: rtl/seq_ctrl_unit.sv
// seq_ctrl_unit: hardwired instruction sequencer producing datapath strobes per step.
// Define SEQ_CTRL_WAIT_EN to stall memory steps until mem_rdy; otherwise memory is zero-wait.
module seq_ctrl_unit
    import seq_ctrl_pkg::*;
#(
    parameter int NSTEP = 8,
    parameter int IR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   din,
    input  logic [1:0]        cpustate,
    input  logic              z,
    input  logic              mem_rdy,
    output logic [CTRL_W-1:0] ctrl,
    output logic [3:0]        alus,
    output logic [NSTEP-1:0]  step,
    output logic              clr,
    output logic              illegal,
    output logic              wdog
);

    opcode_t opcode_q;
    logic    taken_q;
    logic    illegal_q;
    logic    running;
    logic    stall;
    logic    advance;
    logic    restart;
    logic    taken_d;
    ctrl_t   dec;
    logic    dec_clr;

    assign running = reset && (cpustate == RUN);
    assign advance = running && !stall;
    assign restart = !running || clr;
    assign taken_d = (opcode_q == OP_JMP) || ((opcode_q == OP_JPZ) && z) ||
                     ((opcode_q == OP_JPNZ) && !z);

`ifdef SEQ_CTRL_WAIT_EN
    assign stall = running && (dec[READ] || dec[WRITE]) && !mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign stall = 1'b0;
`endif

    seq_step_ring #(.NSTEP(NSTEP)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .restart (restart),
        .step    (step)
    );

    // A nonzero modifier demotes the instruction to NOP and flags it for T3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q  <= OP_NOP;
            alus      <= ALU_CLR;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (advance) begin
            if (step[2]) begin
                if (|din[IR_W-5:0]) begin
                    opcode_q  <= OP_NOP;
                    illegal_q <= 1'b1;
                    alus      <= alus_of(OP_NOP);
                end else begin
                    opcode_q  <= opcode_t'(din[IR_W-1:IR_W-4]);
                    illegal_q <= 1'b0;
                    alus      <= alus_of(opcode_t'(din[IR_W-1:IR_W-4]));
                end
            end
            if (step[3]) begin
                taken_q <= taken_d;
            end
        end
    end

    always_comb begin
        dec     = '0;
        dec_clr = 1'b0;
        if (step[0]) begin
            dec[PCBUS] = 1'b1; dec[ARLOAD] = 1'b1;
        end else if (step[1]) begin
            dec[READ] = 1'b1; dec[MEMBUS] = 1'b1; dec[DRLOAD] = 1'b1; dec[PCINC] = 1'b1;
        end else if (step[2]) begin
            dec[PCBUS] = 1'b1; dec[ARLOAD] = 1'b1; dec[IRLOAD] = 1'b1;
        end else if (illegal_q) begin
            dec_clr = step[3];
        end else begin
            case (opcode_q)
                OP_NOP: dec_clr = step[3];
                OP_CLR: if (step[3]) begin
                    dec[R0LOAD] = 1'b1; dec[ZLOAD] = 1'b1; dec_clr = 1'b1;
                end
                OP_MVR: if (step[3]) begin
                    dec[R0BUS] = 1'b1; dec[R1LOAD] = 1'b1; dec_clr = 1'b1;
                end
                // DRHBUS and TRBUS together drive one address: high byte from DR, low from TR
                OP_JMP, OP_JPZ, OP_JPNZ: begin
                    if (step[3]) begin
                        dec[READ] = 1'b1; dec[MEMBUS] = 1'b1; dec[TRLOAD] = 1'b1;
                        dec[ARINC] = 1'b1; dec[PCINC] = 1'b1;
                    end else if (step[4] && taken_q) begin
                        dec[READ] = 1'b1; dec[MEMBUS] = 1'b1; dec[DRLOAD] = 1'b1;
                    end else if (step[4]) begin
                        dec[PCINC] = 1'b1; dec_clr = 1'b1;
                    end else if (step[5] && taken_q) begin
                        dec[DRHBUS] = 1'b1; dec[TRBUS] = 1'b1; dec[PCLOAD] = 1'b1;
                        dec_clr = 1'b1;
                    end
                end
                OP_LAD, OP_STO: begin
                    if (step[3]) begin
                        dec[READ] = 1'b1; dec[MEMBUS] = 1'b1; dec[TRLOAD] = 1'b1;
                        dec[ARINC] = 1'b1; dec[PCINC] = 1'b1;
                    end else if (step[4]) begin
                        dec[TRBUS] = 1'b1; dec[ARLOAD] = 1'b1;
                    end else if (step[5] && opcode_q == OP_LAD) begin
                        dec[READ] = 1'b1; dec[MEMBUS] = 1'b1; dec[DRLOAD] = 1'b1;
                    end else if (step[5]) begin
                        dec[WRITE] = 1'b1; dec[BUSMEM] = 1'b1; dec[R0BUS] = 1'b1;
                    end else if (step[6] && opcode_q == OP_LAD) begin
                        dec[DRLBUS] = 1'b1; dec[R0LOAD] = 1'b1;
                    end else if (step[7]) begin
                        dec[PCINC] = 1'b1; dec_clr = 1'b1;
                    end
                end
                default: begin
                    if (step[3]) begin
                        dec[R1BUS] = 1'b1; dec[XLOAD] = 1'b1;
                    end else if (step[4]) begin
                        dec[R0LOAD] = 1'b1; dec[ZLOAD] = 1'b1; dec_clr = 1'b1;
                    end
                end
            endcase
        end
    end

    // Watchdog takes precedence; a stall keeps bus/memory strobes but drops loads and clr
    always_comb begin
        ctrl    = '0;
        clr     = 1'b0;
        illegal = 1'b0;
        wdog    = 1'b0;
        if (running) begin
            if (step[NSTEP-1] && !dec_clr) begin
                clr  = 1'b1;
                wdog = 1'b1;
            end else if (stall) begin
                ctrl = dec & ~LOAD_MASK;
            end else begin
                ctrl    = dec;
                clr     = dec_clr;
                illegal = illegal_q && step[3];
            end
        end
    end

endmodule
